// File: rtl/multicycle_control_unit_pkg.sv
// rtl/multicycle_control_unit_pkg.sv - shared encodings for the multicycle RV32I controller
package multicycle_control_unit_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SUB  = 6'd1;
  localparam logic [5:0] ALU_SLL  = 6'd2;
  localparam logic [5:0] ALU_SLT  = 6'd3;
  localparam logic [5:0] ALU_SLTU = 6'd4;
  localparam logic [5:0] ALU_XOR  = 6'd5;
  localparam logic [5:0] ALU_SRL  = 6'd6;
  localparam logic [5:0] ALU_SRA  = 6'd7;
  localparam logic [5:0] ALU_OR   = 6'd8;
  localparam logic [5:0] ALU_AND  = 6'd9;

  // States in which the shared memory port may stall on mem_ready.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - controller <-> datapath signal bundle
interface multicycle_control_unit_if;
  import multicycle_control_unit_pkg::*;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       Neg;
  logic       Carry;
  logic       Ovf;
  logic       mem_ready;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [5:0] ALUControl;
  logic       instr_done;
  logic       illegal;
  logic       mem_timeout;

  modport master (
    input  op, funct3, funct7b5, Zero, Neg, Carry, Ovf, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_done, illegal, mem_timeout
  );

  modport slave (
    output op, funct3, funct7b5, Zero, Neg, Carry, Ovf, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_done, illegal, mem_timeout
  );

endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// rtl/multicycle_control_unit_alu_decoder.sv - ALUOp/funct to ALUControl decode
module ALU_Decoder
  import multicycle_control_unit_pkg::*;
(
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] ALUOp,
  output logic [5:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op bit 5 set) distinguishes sub from add.
          3'b000:  ALUControl = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  ALUControl = ALU_SLL;
          3'b010:  ALUControl = ALU_SLT;
          3'b011:  ALUControl = ALU_SLTU;
          3'b100:  ALUControl = ALU_XOR;
          3'b101:  ALUControl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - Moore FSM controller for the shared-port multicycle RV32I core
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int EN_BRANCH_ALL = 1,
  parameter int MEM_WAIT      = 1,
  parameter int TIMEOUT       = 255
)(
  input  logic                          clk,
  input  logic                          reset,
  multicycle_control_unit_if.master     bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] wait_cnt;

  logic       rdy;
  logic       timeout;
  logic       taken;
  logic       br_legal;
  logic       is_store;
  logic [1:0] alu_op;

  logic       pc_write;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       done;
  logic       ill;
  logic       tmo;

  assign rdy      = (MEM_WAIT != 0) ? bus.mem_ready : 1'b1;
  assign timeout  = is_wait_state(state) && !rdy && (wait_cnt == CW'(TIMEOUT));
  assign is_store = (bus.op == OP_STORE);

  always_comb begin
    taken = 1'b0;
    case (bus.funct3)
      F3_BEQ:  taken = bus.Zero;
      F3_BNE:  taken = !bus.Zero;
      F3_BLT:  taken = bus.Neg ^ bus.Ovf;
      F3_BGE:  taken = !(bus.Neg ^ bus.Ovf);
      F3_BLTU: taken = !bus.Carry;
      F3_BGEU: taken = bus.Carry;
      default: taken = 1'b0;
    endcase
  end

  assign br_legal = (EN_BRANCH_ALL != 0) ? !((bus.funct3 == 3'b010) || (bus.funct3 == 3'b011))
                                         : (bus.funct3 == F3_BEQ);

  // The counter restarts on every state change and after an abort, so each
  // wait episode gets the full TIMEOUT budget.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (timeout || (state_next != state)) begin
        wait_cnt <= '0;
      end else if (is_wait_state(state) && !rdy) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_next    = state;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    done          = 1'b0;
    ill           = 1'b0;
    tmo           = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ResultSrc = RES_ALUOUT;
    bus.ALUSrcA   = SRCA_PC;
    bus.ALUSrcB   = SRCB_RS2;
    bus.ImmSrc    = IMM_I;
    alu_op        = ALUOP_ADD;

    case (state)
      S_FETCH: begin
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        ir_write      = rdy;
        pc_write      = rdy;
        if (rdy) begin
          state_next = S_DECODE;
        end else if (timeout) begin
          tmo        = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        bus.ImmSrc  = IMM_B;
        case (bus.op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          default: begin
            ill        = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ImmSrc  = is_store ? IMM_S : IMM_I;
        state_next  = is_store ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.AdrSrc = 1'b1;
        if (rdy) begin
          state_next = S_MEMWB;
        end else if (timeout) begin
          tmo        = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_MEMWRITE: begin
        bus.AdrSrc = 1'b1;
        mem_write  = 1'b1;
        if (rdy) begin
          done       = 1'b1;
          state_next = S_FETCH;
        end else if (timeout) begin
          tmo        = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_MEMWB: begin
        bus.ResultSrc = RES_DATA;
        reg_write     = 1'b1;
        done          = 1'b1;
        state_next    = S_FETCH;
      end
      S_EXECR: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_RS2;
        alu_op      = ALUOP_FUNCT;
        state_next  = S_ALUWB;
      end
      S_EXECI: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ImmSrc  = IMM_I;
        alu_op      = ALUOP_FUNCT;
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        bus.ResultSrc = RES_ALUOUT;
        reg_write     = 1'b1;
        done          = 1'b1;
        state_next    = S_FETCH;
      end
      S_JAL: begin
        bus.ALUSrcA   = SRCA_OLDPC;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALUOUT;
        pc_write      = 1'b1;
        state_next    = S_ALUWB;
      end
      S_BRANCH: begin
        bus.ALUSrcA   = SRCA_RS1;
        bus.ALUSrcB   = SRCB_RS2;
        bus.ResultSrc = RES_ALUOUT;
        alu_op        = ALUOP_SUB;
        state_next    = S_FETCH;
        if (br_legal) begin
          pc_write = taken;
          done     = 1'b1;
        end else begin
          ill = 1'b1;
        end
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Strobes are masked combinationally so a reset mid-instruction writes nothing.
  assign bus.PCWrite     = pc_write  & ~reset;
  assign bus.IRWrite     = ir_write  & ~reset;
  assign bus.MemWrite    = mem_write & ~reset;
  assign bus.RegWrite    = reg_write & ~reset;
  assign bus.instr_done  = done      & ~reset;
  assign bus.illegal     = ill       & ~reset;
  assign bus.mem_timeout = tmo       & ~reset;

  ALU_Decoder u_alu_decoder (
    .opb5       (bus.op[5]),
    .funct3     (bus.funct3),
    .funct7b5   (bus.funct7b5),
    .ALUOp      (alu_op),
    .ALUControl (bus.ALUControl)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - instruction-level model check of multicycle_control_unit
module tb_multicycle_control_unit;
  import multicycle_control_unit_pkg::*;

  localparam int TMO = 4;
  localparam int C_ADR = 1, C_SA = 2, C_SB = 4, C_IM = 8, C_ALU = 16, C_RES = 32;

  typedef struct packed {
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] immsrc;
    logic [5:0] aluctl;
    logic       done;
    logic       illegal;
    logic       tmo;
  } ctl_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z, n, c, v;
    logic       rdy;
    int         tag;
    ctl_t       ea, ma, eb, mb;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_unit_if ifa ();
  multicycle_control_unit_if ifb ();

  multicycle_control_unit #(.EN_BRANCH_ALL(1), .MEM_WAIT(1), .TIMEOUT(TMO)) dut_a (
    .clk(clk), .reset(rst), .bus(ifa));
  multicycle_control_unit #(.EN_BRANCH_ALL(0), .MEM_WAIT(1), .TIMEOUT(TMO)) dut_b (
    .clk(clk), .reset(rst), .bus(ifb));

  ctl_t act_a, act_b;
  assign act_a = {ifa.PCWrite, ifa.AdrSrc, ifa.MemWrite, ifa.IRWrite, ifa.RegWrite, ifa.ResultSrc,
                  ifa.ALUSrcA, ifa.ALUSrcB, ifa.ImmSrc, ifa.ALUControl, ifa.instr_done,
                  ifa.illegal, ifa.mem_timeout};
  assign act_b = {ifb.PCWrite, ifb.AdrSrc, ifb.MemWrite, ifb.IRWrite, ifb.RegWrite, ifb.ResultSrc,
                  ifb.ALUSrcA, ifb.ALUSrcB, ifb.ImmSrc, ifb.ALUControl, ifb.instr_done,
                  ifb.illegal, ifb.mem_timeout};

  rec_t q[$];
  rec_t cur;
  bit   cur_valid = 0;
  ctl_t e, m, eb, mb;
  bit   g_sep = 0;
  logic [6:0] g_op;
  logic [2:0] g_f3;
  logic g_f7, g_z, g_n, g_c, g_v;
  int   g_tag;
  int   n_cmp = 0, n_bad = 0, ncyc = 0;
  int   cyc[16], done_a[16], regw_a[16], pcw_a[16], memw_a[16], tmo_a[16], ill_a[16];
  int   ill_b[16], pcw_b[16];

  function automatic logic [5:0] exp_alu(input logic opb5, input logic [2:0] f3, input logic f7b5);
    case (f3)
      3'd0: return (opb5 && f7b5) ? ALU_SUB : ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return f7b5 ? ALU_SRA : ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Fields outside 'care' are left unchecked; strobes are always checked.
  task automatic mk(input logic adr, input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] im,
                    input logic [5:0] alu, input logic [1:0] rs, input int care);
    e = '0; m = '0;
    m.pcwrite = 1; m.memwrite = 1; m.irwrite = 1; m.regwrite = 1;
    m.done = 1; m.illegal = 1; m.tmo = 1;
    if (care & C_ADR) begin e.adrsrc = adr; m.adrsrc = 1'b1; end
    if (care & C_SA)  begin e.srca = sa; m.srca = 2'b11; end
    if (care & C_SB)  begin e.srcb = sb; m.srcb = 2'b11; end
    if (care & C_IM)  begin e.immsrc = im; m.immsrc = 2'b11; end
    if (care & C_ALU) begin e.aluctl = alu; m.aluctl = 6'h3f; end
    if (care & C_RES) begin e.resultsrc = rs; m.resultsrc = 2'b11; end
  endtask

  task automatic push(input logic r, input logic rdy);
    rec_t x;
    x.rst = r; x.op = g_op; x.f3 = g_f3; x.f7 = g_f7;
    x.z = g_z; x.n = g_n; x.c = g_c; x.v = g_v;
    x.rdy = rdy; x.tag = g_tag; x.ea = e; x.ma = m;
    x.eb = g_sep ? eb : e;
    x.mb = g_sep ? mb : m;
    q.push_back(x);
  endtask

  task automatic ph_mem(input int kind);
    if (kind == 0) mk(1'b0, SRCA_PC, SRCB_FOUR, 2'b0, ALU_ADD, RES_ALURESULT, C_ADR|C_SA|C_SB|C_ALU|C_RES);
    else           mk(1'b1, 2'b0, 2'b0, 2'b0, 6'd0, 2'b0, C_ADR);
    if (kind == 2) e.memwrite = 1'b1;
  endtask

  // kind 0 fetch, 1 load, 2 store; w = cycles of mem_ready low before it rises.
  task automatic plan_wait(input int kind, input int w, output bit ok);
    if (w > TMO) begin
      for (int i = 0; i <= TMO; i++) begin
        ph_mem(kind);
        if (i == TMO) e.tmo = 1'b1;
        push(1'b0, 1'b0);
      end
      ok = 0;
    end else begin
      for (int i = 0; i < w; i++) begin ph_mem(kind); push(1'b0, 1'b0); end
      ph_mem(kind);
      if (kind == 0) begin e.irwrite = 1'b1; e.pcwrite = 1'b1; end
      if (kind == 2) e.done = 1'b1;
      push(1'b0, 1'b1);
      ok = 1;
    end
  endtask

  task automatic plan_reset(input int tag);
    g_tag = tag;
    ph_mem(0);
    push(1'b1, 1'b1);
  endtask

  task automatic writeback(input logic [1:0] rs);
    mk(1'b0, 2'b0, 2'b0, 2'b0, 6'd0, rs, C_RES);
    e.regwrite = 1'b1; e.done = 1'b1;
    push(1'b0, 1'($urandom));
  endtask

  // kind: 0 R, 1 I, 2 lw, 3 sw, 4 branch, 5 jal, 6 op = xop (unsupported)
  task automatic plan_instr(input int kind, input logic [6:0] xop, input logic [2:0] f3, input logic f7,
                            input logic [31:0] a, input logic [31:0] b, input int wf, input int wm,
                            input bit rst_wb, input int tag);
    bit ok;
    logic [31:0] d;
    logic tk, la, lb;
    g_tag = tag; g_f3 = f3; g_f7 = f7;
    {g_z, g_n, g_c, g_v} = 4'($urandom_range(0, 15));
    case (kind)
      0: g_op = OP_RTYPE;
      1: g_op = OP_ITYPE;
      2: g_op = OP_LOAD;
      3: g_op = OP_STORE;
      4: g_op = OP_BRANCH;
      5: g_op = OP_JAL;
      default: g_op = xop;
    endcase
    plan_wait(0, wf, ok);
    if (!ok) return;
    mk(1'b0, SRCA_OLDPC, SRCB_IMM, IMM_B, ALU_ADD, 2'b0, C_SA|C_SB|C_IM|C_ALU);
    if (kind == 6) e.illegal = 1'b1;
    push(1'b0, 1'($urandom));
    case (kind)
      0: begin
        mk(1'b0, SRCA_RS1, SRCB_RS2, 2'b0, exp_alu(g_op[5], f3, f7), 2'b0, C_SA|C_SB|C_ALU);
        push(1'b0, 1'($urandom));
        writeback(RES_ALUOUT);
      end
      1: begin
        mk(1'b0, SRCA_RS1, SRCB_IMM, IMM_I, exp_alu(g_op[5], f3, f7), 2'b0, C_SA|C_SB|C_IM|C_ALU);
        push(1'b0, 1'($urandom));
        writeback(RES_ALUOUT);
      end
      2, 3: begin
        mk(1'b0, SRCA_RS1, SRCB_IMM, (kind == 3) ? IMM_S : IMM_I, ALU_ADD, 2'b0, C_SA|C_SB|C_IM|C_ALU);
        push(1'b0, 1'($urandom));
        plan_wait(kind - 1, wm, ok);
        if (ok && kind == 2) begin
          if (rst_wb) begin ph_mem(0); push(1'b1, 1'b1); end
          else writeback(RES_DATA);
        end
      end
      4: begin
        // ALU flags of a - b, and the branch outcome from the ISA comparison itself.
        d = a - b;
        g_z = (d == 32'd0); g_n = d[31]; g_c = (a >= b);
        g_v = (a[31] != b[31]) && (d[31] != a[31]);
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: tk = 1'b0;
        endcase
        la = (f3 != 3'd2) && (f3 != 3'd3);
        lb = (f3 == 3'd0);
        mk(1'b0, SRCA_RS1, SRCB_RS2, 2'b0, ALU_SUB, RES_ALUOUT, C_SA|C_SB|C_ALU|C_RES);
        eb = e; mb = m;
        e.pcwrite  = la && tk; e.done  = la; e.illegal  = !la;
        eb.pcwrite = lb && tk; eb.done = lb; eb.illegal = !lb;
        g_sep = 1;
        push(1'b0, 1'($urandom));
        g_sep = 0;
      end
      5: begin
        mk(1'b0, SRCA_OLDPC, SRCB_FOUR, 2'b0, ALU_ADD, RES_ALUOUT, C_SA|C_SB|C_ALU|C_RES);
        e.pcwrite = 1'b1;
        push(1'b0, 1'($urandom));
        writeback(RES_ALUOUT);
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    #3;
    if (cur_valid) begin
      ncyc++;
      n_cmp++;
      if (((act_a ^ cur.ea) & cur.ma) != '0) begin
        n_bad++;
        $display("FAIL ctl_a cycle %0d tag %0d: got %h want %h (care %h)", ncyc, cur.tag, act_a, cur.ea, cur.ma);
      end
      n_cmp++;
      if (((act_b ^ cur.eb) & cur.mb) != '0) begin
        n_bad++;
        $display("FAIL ctl_b cycle %0d tag %0d: got %h want %h (care %h)", ncyc, cur.tag, act_b, cur.eb, cur.mb);
      end
      cyc[cur.tag]++;
      done_a[cur.tag] += int'(act_a.done);
      regw_a[cur.tag] += int'(act_a.regwrite);
      pcw_a[cur.tag]  += int'(act_a.pcwrite);
      memw_a[cur.tag] += int'(act_a.memwrite);
      tmo_a[cur.tag]  += int'(act_a.tmo);
      ill_a[cur.tag]  += int'(act_a.illegal);
      ill_b[cur.tag]  += int'(act_b.illegal);
      pcw_b[cur.tag]  += int'(act_b.pcwrite);
    end
  end

  task automatic lit(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic drive(input rec_t r);
    rst = r.rst;
    ifa.op = r.op; ifa.funct3 = r.f3; ifa.funct7b5 = r.f7; ifa.mem_ready = r.rdy;
    ifa.Zero = r.z; ifa.Neg = r.n; ifa.Carry = r.c; ifa.Ovf = r.v;
    ifb.op = r.op; ifb.funct3 = r.f3; ifb.funct7b5 = r.f7; ifb.mem_ready = r.rdy;
    ifb.Zero = r.z; ifb.Neg = r.n; ifb.Carry = r.c; ifb.Ovf = r.v;
  endtask

  function automatic int rw();
    int r;
    r = $urandom_range(0, 11);
    return (r < 6) ? 0 : r - 6;
  endfunction

  initial begin
    rec_t z;
    logic [6:0] xo;
    logic [31:0] a, b;
    int k;
    for (int i = 0; i < 16; i++) begin
      cyc[i] = 0; done_a[i] = 0; regw_a[i] = 0; pcw_a[i] = 0; memw_a[i] = 0;
      tmo_a[i] = 0; ill_a[i] = 0; ill_b[i] = 0; pcw_b[i] = 0;
    end
    z.rst = 1'b1; z.op = '0; z.f3 = '0; z.f7 = 1'b0; z.z = 0; z.n = 0; z.c = 0; z.v = 0; z.rdy = 1'b0;
    drive(z);

    plan_reset(0); plan_reset(0);
    plan_instr(0, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 0, 0, 0, 1);               // add x3,x1,x2
    plan_instr(2, 7'd0, 3'd2, 1'b0, 32'd0, 32'd0, 0, 3, 0, 2);               // lw, 3 wait cycles
    plan_instr(4, 7'd0, 3'd1, 1'b0, 32'd5, 32'd7, 0, 0, 0, 3);               // bne, not equal
    plan_instr(4, 7'd0, 3'd1, 1'b0, 32'd9, 32'd9, 0, 0, 0, 4);               // bne, equal
    plan_instr(4, 7'd0, 3'd6, 1'b0, 32'd3, 32'h8000_0000, 0, 0, 0, 5);       // bltu, Carry=0
    plan_instr(3, 7'd0, 3'd2, 1'b0, 32'd0, 32'd0, 0, TMO + 1, 0, 6);         // sw timeout
    plan_instr(6, 7'b0000000, 3'd0, 1'b0, 32'd0, 32'd0, 0, 0, 0, 7);         // op 0
    plan_instr(2, 7'd0, 3'd2, 1'b0, 32'd0, 32'd0, 0, 0, 1, 8);               // lw, reset in MEMWB
    plan_instr(0, 7'd0, 3'd0, 1'b1, 32'd0, 32'd0, 0, 0, 0, 9);
    plan_instr(0, 7'd0, 3'd7, 1'b0, 32'd0, 32'd0, TMO, 0, 0, 10);            // ready on the last allowed cycle
    plan_instr(1, 7'd0, 3'd5, 1'b1, 32'd0, 32'd0, TMO + 1, 0, 0, 11);        // fetch abort

    for (int i = 0; i < 120; i++) begin
      k = $urandom_range(0, 6);
      do xo = 7'($urandom_range(0, 127));
      while (xo inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL});
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      plan_instr(k, xo, 3'($urandom_range(0, 7)), 1'($urandom), a, b, rw(), rw(), 0, 0);
    end

    while (q.size() > 0) begin
      @(negedge clk);
      cur = q.pop_front();
      drive(cur);
      cur_valid = 1;
    end
    @(negedge clk);
    cur_valid = 0;
    #5;

    lit("add_cycles", cyc[1], 4);
    lit("add_done", done_a[1], 1);
    lit("add_regwrite", regw_a[1], 1);
    lit("lw_cycles", cyc[2], 8);
    lit("lw_regwrite", regw_a[2], 1);
    lit("bne_taken_pcwrite", pcw_a[3], 2);
    lit("bne_beqonly_illegal", ill_b[3], 1);
    lit("bne_beqonly_pcwrite", pcw_b[3], 1);
    lit("bne_equal_pcwrite", pcw_a[4], 1);
    lit("bltu_pcwrite", pcw_a[5], 2);
    lit("sw_tmo_memwrite", memw_a[6], 5);
    lit("sw_tmo_pulse", tmo_a[6], 1);
    lit("sw_tmo_done", done_a[6], 0);
    lit("sw_tmo_cycles", cyc[6], 8);
    lit("illop_illegal", ill_a[7], 1);
    lit("illop_cycles", cyc[7], 2);
    lit("rst_wb_regwrite", regw_a[8], 0);
    lit("rst_wb_done", done_a[8], 0);
    lit("post_rst_done", done_a[9], 1);
    lit("fetch_edge_cycles", cyc[10], 8);
    lit("fetch_edge_tmo", tmo_a[10], 0);
    lit("fetch_abort_tmo", tmo_a[11], 1);
    lit("fetch_abort_pcwrite", pcw_a[11], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore-style FSM controller for the multicycle RV32I core. Replaces the single-cycle controller when instruction and data memory share one port.
- Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives the datapath muxes, the write strobes and ALUControl.
- Adds two behaviours: a memory wait handshake with timeout, and full conditional-branch support (beq/bne/blt/bge/bltu/bgeu) from ALU flags.

Parameters:
- EN_BRANCH_ALL, 1: 1 = all six branches supported; 0 = beq only, other branch funct3 values are illegal.
- MEM_WAIT, 1: 1 = honour mem_ready; 0 = treat mem_ready as constant 1.
- TIMEOUT, 255: maximum wait cycles on mem_ready before abort; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- op  in  7  instruction opcode from the IR
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- Zero, Neg, Carry, Ovf  in  1 each  ALU flags from the current cycle's ALU result
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  IR and OldPC enable
- RegWrite  out  1  register file write strobe
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1
- ALUSrcB  out  2  00 rs2, 01 ImmExt, 10 constant 4
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- ALUControl  out  6  ALU operation code
- instr_done  out  1  one-cycle pulse on the final state of each instruction
- illegal  out  1  one-cycle pulse on an unsupported op or funct3
- mem_timeout  out  1  one-cycle pulse on a wait abort

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL.
- Reset:
  - While reset is high: state=FETCH, wait counter=0, and PCWrite, IRWrite, MemWrite, RegWrite, instr_done, illegal, mem_timeout are all forced to 0 combinationally.
  - Mux selects take their FETCH values during reset.
  - Reset asserted mid-instruction aborts it with no further writes.
- FETCH:
  - Outputs: AdrSrc=0, SrcA=00, SrcB=10, ALU add, ResultSrc=10.
  - IRWrite and PCWrite = mem_ready.
  - Moves to DECODE on mem_ready; otherwise holds.
- DECODE:
  - Outputs: SrcA=01, SrcB=01, ImmSrc=10, ALU add (branch target into ALUOut).
  - op 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL.
  - Any other op -> FETCH with illegal=1.
- MEMADR:
  - Outputs: SrcA=10, SrcB=01, ImmSrc = 01 if store else 00, ALU add.
  - Load -> MEMREAD; store -> MEMWRITE.
- MEMREAD: AdrSrc=1. Waits for mem_ready, then -> MEMWB.
- MEMWRITE: AdrSrc=1, MemWrite=1, held every wait cycle. On mem_ready -> FETCH with instr_done=1.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1 -> FETCH.
- EXECR / EXECI:
  - SrcA=10; SrcB=00 (EXECR) or 01 (EXECI, ImmSrc=00).
  - ALUControl comes from the ALU_Decoder sub-module with ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1 -> FETCH.
- JAL: SrcA=01, SrcB=10, ALU add, ResultSrc=00, PCWrite=1 -> ALUWB.
- BRANCH:
  - SrcA=10, SrcB=00, ALU subtract, ResultSrc=00.
  - PCWrite = taken. instr_done=1 -> FETCH.
  - taken: 000 Zero; 001 !Zero; 100 Neg^Ovf; 101 !(Neg^Ovf); 110 !Carry; 111 Carry.
  - funct3 010/011, or any non-000 when EN_BRANCH_ALL=0: PCWrite=0, illegal=1, no instr_done.
- Wait counter:
  - Cleared on entry to FETCH, MEMREAD or MEMWRITE; increments each cycle mem_ready=0 there.
  - When the count equals TIMEOUT with mem_ready still 0: mem_timeout=1 and next state is FETCH with no IR, PC or register write.
  - mem_ready=1 in the TIMEOUT cycle wins over the abort.
- Latency in cycles with zero wait: lw 5, sw 4, R/I 4, branch 3, jal 4.

Decomposition:
- Shared package holds the state encoding (4-bit enum), the opcode constants, the ALUSrcA/ALUSrcB/ResultSrc/ImmSrc encodings, and the branch funct3 constants.
- One sub-module: the existing ALU_Decoder (inputs opb5, funct3, funct7b5, ALUOp), instantiated unchanged; ALUOp is produced per state.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready=1 -> states F,D,EXECR,ALUWB; RegWrite in cycle 4 only; ALUControl = add code; instr_done once.
- lw (op 0000011), mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles, RegWrite only in MEMWB, total 8 cycles.
- bne with Zero=0, then with Zero=1 -> PCWrite=1, then PCWrite=0 in BRANCH; bltu with Carry=0 -> taken. EN_BRANCH_ALL=0 with bne -> illegal pulse, no PCWrite.
- sw with TIMEOUT=4, mem_ready=0 -> MemWrite high 5 cycles, mem_timeout pulse, back to FETCH, no instr_done.
- op 0000000 -> illegal pulse in DECODE, back to FETCH, no write strobes.
- reset asserted during MEMWB -> RegWrite drops to 0 immediately; state=FETCH after release; first fetch completes normally.
